key_event_arb: RTL and testbench
================================

KEY_EVENT_ARB -- requirements
Module: key_event_arb

Interface
REQ-001 SHALL have parameter W, default 3: number of debounced key channels.
REQ-002 SHALL have parameter DEPTH, default 4: event FIFO depth, power of two, at least 2.
REQ-003 SHALL have parameter IDW, default 2: key-index width, at least clog2(W).
REQ-004 SHALL have port clk, input, 1 bit: sole clock; all logic updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port key_flag, input, W bits: per-key one-cycle press pulse from the debouncers, active high.
REQ-007 SHALL have port ev_ready, input, 1 bit: the consumer accepts the head event.
REQ-008 SHALL have port clr_ovf, input, 1 bit: clears the overflow flag.
REQ-009 SHALL have port ev_valid, output, 1 bit: the FIFO head holds an event.
REQ-010 SHALL have port ev_id, output, IDW bits: key index of the head event.
REQ-011 SHALL have port pending, output, W bits: per-key latched, not-yet-queued press.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag for a dropped press.
REQ-013 SHALL have port count, output, clog2(DEPTH)+1 bits: FIFO occupancy.

Function
REQ-014 SHALL set pending[i] on the edge after key_flag[i]=1.
REQ-015 SHALL clear pending[i] on the edge where key i is granted into the FIFO.
- Exception: if key_flag[i]=1 in the grant cycle, pending[i] stays 1 and the new press is kept.
REQ-016 SHALL treat key_flag[i]=1 while pending[i]=1 and key i is not granted that cycle as a dropped press.
- The pulse is discarded and overflow is set on that edge.
REQ-017 SHALL clear overflow on the edge where clr_ovf=1.
- If clr_ovf coincides with a new drop, set wins and overflow stays 1.
REQ-018 SHALL grant at most one pending key per cycle, only when count<DEPTH.
- There is no push-through-on-pop while full.
REQ-019 SHALL use round-robin grant order.
- Search starts at rr_ptr and runs upward modulo W.
- On a grant, rr_ptr becomes (granted index+1) mod W.
- With no grant, rr_ptr holds.
REQ-020 SHALL write the granted index at the FIFO tail on the grant edge.
REQ-021 SHALL present the FIFO in show-ahead form.
- ev_valid=(count!=0); ev_id=head entry.
REQ-022 SHALL pop the head on each edge where ev_valid=1 and ev_ready=1.
REQ-023 SHALL keep ev_id stable while ev_valid=1 and ev_ready=0.
REQ-024 SHALL perform a push and a pop in the same cycle together when count>0.
- count is unchanged in that case.
REQ-025 SHALL wrap read and write pointers modulo DEPTH.
REQ-026 SHALL not let count exceed DEPTH or go below 0.
REQ-027 SHALL deliver a press to an idle, empty arbiter with ev_valid=1 two cycles after the key_flag pulse:
- pulse in cycle N;
- pending set at edge N+1;
- grant and push at edge N+2;
- ev_valid=1 in cycle N+2.

Reset
REQ-028 SHALL, while rst=1, immediately force all of the following to 0:
- pending, overflow, count, ev_valid, ev_id;
- rr_ptr and the FIFO pointers.
REQ-029 SHALL discard all pending and queued events on a reset asserted mid-operation.
REQ-030 SHALL resume normal operation on the first rising edge after rst deasserts.

Verification
REQ-031 Single press: W=3, DEPTH=4, ev_ready=1, key_flag=001 for one cycle.
- ev_valid=1, ev_id=0 for exactly one cycle, 2 cycles after the pulse; overflow stays 0.
REQ-032 Simultaneous presses: ev_ready=0, key_flag=111 for one cycle, then 111 again after 5 cycles.
- count reaches 4; pending=110.
- Then ev_ready=1: ev_id sequence is 0,1,2,0,1,2; pending ends 000.
REQ-033 Overflow: FIFO full, ev_ready=0, key_flag=010 twice, 3 cycles apart.
- overflow=1 after the second pulse; exactly one additional key-1 event is delivered later.
- clr_ovf pulse: overflow=0 on the next edge.
REQ-034 Backpressure: ev_valid=1, ev_ready=0 for 10 cycles.
- ev_id and count are constant; a new press only raises count by 1.
REQ-035 Concurrent push and pop: count=2, ev_ready=1, new press granted in the same cycle.
- count remains 2; order is preserved.
REQ-036 Reset mid-operation: count=3, pending=101, rst pulsed for 1 cycle.
- All outputs are 0 immediately.
- The next key_flag=100 is delivered as ev_id=2 two cycles later.

Source files
------------

// File: rtl/key_event_arb.sv
// key_event_arb: latches debounced key press pulses, grants them round-robin
// into a show-ahead event FIFO, and flags presses lost while one is still pending.
module key_event_arb #(
  parameter int W = 3,
  parameter int DEPTH = 4,
  parameter int IDW = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             key_flag,
  input  logic                     ev_ready,
  input  logic                     clr_ovf,
  output logic                     ev_valid,
  output logic [IDW-1:0]           ev_id,
  output logic [W-1:0]             pending,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]   r_pend;
  logic           r_ovf;
  logic [AW:0]    r_cnt;
  logic [AW-1:0]  r_wp, r_rp;
  logic [IDW-1:0] r_rr;
  logic [IDW-1:0] r_mem [DEPTH];
  logic           w_hit, w_gnt, w_pop, w_drop;
  logic [IDW-1:0] w_gid;
  logic [W-1:0]   w_gvec, w_pend_nx;
  // Lowest pending index at or above rr_ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    w_hit = 1'b0;
    w_gid = '0;
    for (int i = W - 1; i >= 0; i--)
      if (r_pend[i] && IDW'(i) >= r_rr) begin
        w_hit = 1'b1;
        w_gid = IDW'(i);
      end
    if (!w_hit)
      for (int i = W - 1; i >= 0; i--)
        if (r_pend[i]) begin
          w_hit = 1'b1;
          w_gid = IDW'(i);
        end
  end
  assign w_gnt     = w_hit && (r_cnt != (AW+1)'(DEPTH));
  assign w_gvec    = w_gnt ? W'(1) << w_gid : '0;
  assign w_drop    = |(key_flag & r_pend & ~w_gvec);
  assign w_pend_nx = key_flag | (r_pend & ~w_gvec);
  assign w_pop     = ev_valid & ev_ready;
  assign ev_valid  = r_cnt != '0;
  assign ev_id     = ev_valid ? r_mem[r_rp] : '0;
  assign pending   = r_pend;
  assign overflow  = r_ovf;
  assign count     = r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
      r_cnt  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_rr   <= '0;
    end else begin
      r_pend <= w_pend_nx;
      r_ovf  <= w_drop ? 1'b1 : clr_ovf ? 1'b0 : r_ovf;
      r_cnt  <= r_cnt + (AW+1)'(w_gnt) - (AW+1)'(w_pop);
      r_wp   <= w_gnt ? r_wp + AW'(1) : r_wp;
      r_rp   <= w_pop ? r_rp + AW'(1) : r_rp;
      r_rr   <= !w_gnt ? r_rr : (w_gid == IDW'(W - 1)) ? '0 : w_gid + IDW'(1);
    end
  // Storage needs no reset: ev_id is masked while the FIFO is empty.
  always_ff @(posedge clk)
    if (w_gnt) r_mem[r_wp] <= w_gid;
endmodule

// File: tb/tb_key_event_arb.sv
// tb_key_event_arb: scenario tasks plus a randomized run against a queue-based
// model of the key arbiter and its event FIFO.
module tb_key_event_arb;
  localparam int W = 3, DEPTH = 4, IDW = 2;
  logic clk = 0, rst = 0, ev_ready = 0, clr_ovf = 0;
  logic [W-1:0] key_flag = '0;
  logic ev_valid, overflow;
  logic [IDW-1:0] ev_id;
  logic [W-1:0] pending;
  logic [$clog2(DEPTH):0] count;
  int checks = 0, errors = 0;
  bit m_pend [W];
  int m_q [$];
  int m_rr;
  bit m_ovf;

  key_event_arb #(.W(W), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .key_flag(key_flag), .ev_ready(ev_ready), .clr_ovf(clr_ovf),
    .ev_valid(ev_valid), .ev_id(ev_id), .pending(pending), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_q.delete();
    m_rr = 0;
    m_ovf = 0;
  endfunction

  function automatic void model_edge(logic [W-1:0] f, logic r, logic c);
    int g = -1;
    bit drop = 0;
    if (m_q.size() < DEPTH)
      for (int k = 0; k < W; k++)
        if (g < 0 && m_pend[(m_rr + k) % W]) g = (m_rr + k) % W;
    for (int i = 0; i < W; i++)
      if (i == g) m_pend[i] = f[i];
      else if (f[i] && m_pend[i]) drop = 1;
      else if (f[i]) m_pend[i] = 1;
    if (m_q.size() > 0 && r) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(g);
      m_rr = (g + 1) % W;
    end
    m_ovf = drop ? 1'b1 : c ? 1'b0 : m_ovf;
  endfunction

  function automatic logic [W-1:0] exp_pend();
    logic [W-1:0] v;
    foreach (m_pend[i]) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic int exp_id();
    return m_q.size() > 0 ? m_q[0] : 0;
  endfunction

  task automatic cyc(input logic [W-1:0] f, input logic r, input logic c);
    key_flag = f;
    ev_ready = r;
    clr_ovf = c;
    model_edge(f, r, c);
    @(posedge clk);
    #1;
    key_flag = '0;
    clr_ovf = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    key_flag = '0;
    ev_ready = 0;
    clr_ovf = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    cyc(3'b101, 0, 0);
    cyc(3'b000, 0, 0);
    #2 rst = 1;
    #1;
    model_reset();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid got %0b exp 0", ev_valid); end
    checks++; if (ev_id !== '0) begin errors++; $display("FAIL reset_ev_id got %0d exp 0", ev_id); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending got %b exp 000", pending); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
    @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_single();
    do_reset();
    cyc(3'b001, 1, 0);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_early got %0b exp 0", ev_valid); end
    checks++; if (pending !== 3'b001) begin errors++; $display("FAIL single_pend got %b exp 001", pending); end
    cyc(3'b000, 1, 0);
    checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", ev_valid); end
    checks++; if (ev_id !== 2'd0) begin errors++; $display("FAIL single_id got %0d exp 0", ev_id); end
    cyc(3'b000, 1, 0);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_once got %0b exp 0", ev_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL single_ovf got %0b exp 0", overflow); end
  endtask

  task automatic test_simul();
    int got [$];
    int exp [6] = '{0, 1, 2, 0, 1, 2};
    do_reset();
    cyc(3'b111, 0, 0);
    repeat (4) cyc(3'b000, 0, 0);
    cyc(3'b111, 0, 0);
    cyc(3'b000, 0, 0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL simul_count got %0d exp 4", count); end
    checks++; if (pending !== 3'b110) begin errors++; $display("FAIL simul_pend got %b exp 110", pending); end
    for (int n = 0; n < 12; n++) begin
      if (ev_valid) got.push_back(int'(ev_id));
      cyc(3'b000, 1, 0);
    end
    checks++; if (got.size() != 6) begin errors++; $display("FAIL simul_len got %0d exp 6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++; if (got[i] != exp[i]) begin errors++; $display("FAIL simul_order[%0d] got %0d exp %0d", i, got[i], exp[i]); end
    end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL simul_pend_end got %b exp 000", pending); end
  endtask

  task automatic test_overflow();
    int got [$];
    int exp [5] = '{0, 1, 2, 0, 1};
    do_reset();
    cyc(3'b111, 0, 0);
    repeat (3) cyc(3'b000, 0, 0);
    cyc(3'b001, 0, 0);
    cyc(3'b000, 0, 0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_full got %0d exp 4", count); end
    cyc(3'b010, 0, 0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_first got %0b exp 0", overflow); end
    cyc(3'b000, 0, 0);
    cyc(3'b000, 0, 0);
    cyc(3'b010, 0, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", overflow); end
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL ovf_pend got %b exp 010", pending); end
    for (int n = 0; n < 10; n++) begin
      if (ev_valid) got.push_back(int'(ev_id));
      cyc(3'b000, 1, 0);
    end
    checks++; if (got.size() != 5) begin errors++; $display("FAIL ovf_len got %0d exp 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      checks++; if (got[i] != exp[i]) begin errors++; $display("FAIL ovf_order[%0d] got %0d exp %0d", i, got[i], exp[i]); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow); end
    cyc(3'b000, 1, 1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %0b exp 0", overflow); end
  endtask

  task automatic test_backpressure();
    do_reset();
    cyc(3'b001, 0, 0);
    cyc(3'b000, 0, 0);
    for (int n = 0; n < 10; n++) begin
      cyc(n == 3 ? 3'b010 : 3'b000, 0, 0);
      checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd0) begin errors++; $display("FAIL bp_head[%0d] got v%0b id%0d exp v1 id0", n, ev_valid, ev_id); end
      checks++; if (count !== (n >= 4 ? 3'd2 : 3'd1)) begin errors++; $display("FAIL bp_count[%0d] got %0d exp %0d", n, count, n >= 4 ? 2 : 1); end
    end
  endtask

  task automatic test_push_pop();
    int got [$];
    do_reset();
    cyc(3'b011, 0, 0);
    cyc(3'b000, 0, 0);
    cyc(3'b000, 0, 0);
    cyc(3'b100, 0, 0);
    checks++; if (count !== 3'd2 || pending !== 3'b100) begin errors++; $display("FAIL pp_setup got c%0d p%b exp c2 p100", count, pending); end
    cyc(3'b000, 1, 0);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL pp_count got %0d exp 2", count); end
    for (int n = 0; n < 4; n++) begin
      if (ev_valid) got.push_back(int'(ev_id));
      cyc(3'b000, 1, 0);
    end
    checks++; if (got.size() != 2 || got[0] != 1 || got[1] != 2) begin errors++; $display("FAIL pp_order got %p exp '{1, 2}", got); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc(3'b001, 0, 0);
    cyc(3'b000, 0, 0);
    cyc(3'b001, 0, 0);
    cyc(3'b000, 0, 0);
    cyc(3'b111, 0, 0);
    cyc(3'b000, 0, 0);
    checks++; if (count !== 3'd3 || pending !== 3'b101) begin errors++; $display("FAIL mid_setup got c%0d p%b exp c3 p101", count, pending); end
    #2 rst = 1;
    #1;
    model_reset();
    checks++; if ({ev_valid, ev_id, count, pending, overflow} !== '0) begin errors++; $display("FAIL mid_async got v%0b id%0d c%0d p%b o%0b exp all 0", ev_valid, ev_id, count, pending, overflow); end
    @(posedge clk);
    #1 rst = 0;
    cyc(3'b100, 1, 0);
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL mid_early got %0b exp 0", ev_valid); end
    cyc(3'b000, 1, 0);
    checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd2) begin errors++; $display("FAIL mid_deliver got v%0b id%0d exp v1 id2", ev_valid, ev_id); end
  endtask

  task automatic test_random();
    logic [W-1:0] f;
    logic r, c;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      f = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      r = $urandom_range(0, 99) < ((n % 100) < 50 ? 15 : 80);
      c = $urandom_range(0, 15) == 0;
      cyc(f, r, c);
      checks++; if (ev_valid !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %0b exp %0b", n, ev_valid, m_q.size() > 0); end
      checks++; if (int'(ev_id) != exp_id()) begin errors++; $display("FAIL rnd_id[%0d] got %0d exp %0d", n, ev_id, exp_id()); end
      checks++; if (int'(count) != m_q.size()) begin errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", n, count, m_q.size()); end
      checks++; if (pending !== exp_pend()) begin errors++; $display("FAIL rnd_pend[%0d] got %b exp %b", n, pending, exp_pend()); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d] got %0b exp %0b", n, overflow, m_ovf); end
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_single();
    test_simul();
    test_overflow();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
